ucore_seq: RTL
==============

UCORE_SEQ -- requirements
Module: ucore_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 16, variable/port data width.
REQ-002 SHALL have parameter NVARS, default 8, number of program variables (power of 2, >=2).
REQ-003 SHALL have parameter PROG_DEPTH, default 64, microprogram words (power of 2, <=2^DATA_W).
REQ-004 SHALL have parameter STACK_DEPTH, default 4, call-stack entries.
REQ-005 Derived: VW=log2(NVARS), PW=log2(PROG_DEPTH), IW=4+2*VW+DATA_W; instruction = {op[3:0], rd[VW], rs[VW], imm[DATA_W]}, MSB first.
REQ-006 SHALL have ports:
- clk  input  1  global clock
- aresetn  input  1  asynchronous active-low reset
- prog_we  input  1  microprogram write strobe
- prog_addr  input  PW  write address
- prog_wdata  input  IW  instruction word
- start  input  1  begin execution at PC 0
- in_data  input  DATA_W  data sampled by IN
- out_data  output  DATA_W  registered value from last OUT
- out_valid  output  1  one-cycle pulse per OUT
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse on HALT
- fault  output  1  high in FAULT

Function
REQ-007 SHALL implement FSM states IDLE, RUN, FAULT; reset state IDLE.
REQ-008 prog_we SHALL write prog_wdata to prog_addr only in IDLE or FAULT; ignored in RUN.
REQ-009 start in IDLE or FAULT SHALL set PC=0, empty the stack, clear fault, and enter RUN next cycle; start in RUN SHALL be ignored.
REQ-010 In RUN, one instruction SHALL execute per cycle from asynchronously read program storage at PC; default next PC = (PC+1) mod PROG_DEPTH.
REQ-011 Opcodes: 0 NOP; 1 LDI rd<=imm; 2 ADD rd<=rd+rs; 3 SUB rd<=rd-rs; 4 IN rd<=in_data; 5 OUT out_data<=rd, out_valid=1 next cycle; 6 JMP PC<=imm[PW-1:0]; 7 BNZ if rd!=0 then PC<=imm[PW-1:0]; 8 CALL; 9 RET; 15 HALT.
REQ-012 ADD/SUB SHALL wrap modulo 2^DATA_W; no flags.
REQ-013 Variables SHALL retain values across runs; only reset clears them.
REQ-014 HALT SHALL return to IDLE and pulse done for exactly one cycle, coincident with busy deasserting.
REQ-015 Opcodes 10-14 SHALL enter FAULT with no register, variable or output change.
REQ-016 out_data SHALL hold its value until the next OUT or reset.
REQ-017 An instruction writing rd and reading rd (ADD rd,rd) SHALL use the pre-write value.
REQ-018 PC increment from PROG_DEPTH-1 SHALL wrap to 0.

Reset
REQ-019 While aresetn low: state IDLE, PC 0, stack empty, all variables 0, out_data 0, out_valid/busy/done/fault 0.
REQ-020 Reset asserted mid-RUN SHALL abort execution immediately; program storage contents need not be cleared.

Configuration
REQ-021 Macro UCORE_SEQ_CALL_STACK_EN defined: CALL pushes (PC+1) mod PROG_DEPTH and jumps to imm[PW-1:0]; RET pops into PC; CALL with STACK_DEPTH entries held, or RET with empty stack, SHALL enter FAULT with no push/pop.
REQ-022 Macro undefined: no stack storage; CALL and RET SHALL enter FAULT as illegal opcodes.

Verification
REQ-023 Load {LDI r0,5; LDI r1,3; ADD r0,r1; OUT r0; HALT}, start -> out_data=8 with one out_valid pulse, then done pulse, busy low, 5 RUN cycles.
REQ-024 Loop: LDI r0,3; LDI r1,1; L: SUB r0,r1; BNZ r0,L; OUT r0; HALT -> out_data=0, done after 2+6+2 cycles.
REQ-025 DATA_W=16: LDI r0,0xFFFF; LDI r1,2; ADD r0,r1; OUT r0 -> out_data=0x0001.
REQ-026 With UCORE_SEQ_CALL_STACK_EN, STACK_DEPTH=4: 5 nested CALLs -> fault high after 5th, 4 entries held; then start -> fault clears, RUN from PC 0.
REQ-027 Opcode 12 at PC 2 -> fault high, busy low, out_valid never asserted; prog_we during RUN leaves storage unchanged.
REQ-028 aresetn pulsed low mid-RUN -> all outputs 0, IDLE; subsequent start re-runs loaded program correctly.

Source files
------------

// File: rtl/ucore_seq.sv
// ucore_seq: single-issue microcoded sequencer with a small variable file,
// a writable program store and IN/OUT data ports.
// Build option: define UCORE_SEQ_CALL_STACK_EN to enable CALL/RET with a
// return-address stack; without it CALL/RET are illegal opcodes.
module ucore_seq #(
  parameter  int DATA_W      = 16,
  parameter  int NVARS       = 8,
  parameter  int PROG_DEPTH  = 64,
  parameter  int STACK_DEPTH = 4,
  localparam int VW          = $clog2(NVARS),
  localparam int PW          = $clog2(PROG_DEPTH),
  localparam int IW          = 4 + 2 * VW + DATA_W
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              prog_we,
  input  logic [PW-1:0]     prog_addr,
  input  logic [IW-1:0]     prog_wdata,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              fault
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FAULT = 2'd2} state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_IN   = 4'd4;
  localparam logic [3:0] OP_OUT  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_BNZ  = 4'd7;
  localparam logic [3:0] OP_CALL = 4'd8;
  localparam logic [3:0] OP_RET  = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [PW-1:0] PC_ONE = {{(PW-1){1'b0}}, 1'b1};

  state_t            state_r;
  logic [PW-1:0]     pc_r;
  logic [DATA_W-1:0] vars_r [NVARS];
  logic [DATA_W-1:0] out_data_r;
  logic              out_valid_r;
  logic              busy_r;
  logic              done_r;
  logic              fault_r;
  logic [IW-1:0]     prog_mem [PROG_DEPTH];

  logic [IW-1:0]     instr_s;
  logic [3:0]        op_s;
  logic [VW-1:0]     rd_s;
  logic [VW-1:0]     rs_s;
  logic [DATA_W-1:0] imm_s;
  logic [PW-1:0]     tgt_s;
  logic [PW-1:0]     pc_inc_s;
  logic [DATA_W-1:0] rd_val_s;
  logic [DATA_W-1:0] rs_val_s;

`ifdef UCORE_SEQ_CALL_STACK_EN
  localparam int SW  = $clog2(STACK_DEPTH + 1);
  localparam int SAW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SW-1:0] SP_FULL = SW'(STACK_DEPTH);
  localparam logic [SW-1:0] SP_ONE  = {{(SW-1){1'b0}}, 1'b1};

  logic [PW-1:0] stack_r [STACK_DEPTH];
  logic [SW-1:0] sp_r;
  logic [SW-1:0] sp_dec_s;
  assign sp_dec_s = sp_r - SP_ONE;
`endif

  // Instruction fetch is an asynchronous read of the program store at PC.
  assign instr_s  = prog_mem[pc_r];
  assign op_s     = instr_s[IW-1 -: 4];
  assign rd_s     = instr_s[IW-5 -: VW];
  assign rs_s     = instr_s[IW-5-VW -: VW];
  assign imm_s    = instr_s[DATA_W-1:0];
  assign tgt_s    = imm_s[PW-1:0];
  assign pc_inc_s = pc_r + PC_ONE;   // natural PW-bit wrap at PROG_DEPTH-1
  assign rd_val_s = vars_r[rd_s];
  assign rs_val_s = vars_r[rs_s];

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign fault     = fault_r;

  // Program store write port: loads are only accepted while not running.
  always_ff @(posedge clk) begin
    if (prog_we && (state_r != S_RUN)) begin
      prog_mem[prog_addr] <= prog_wdata;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r     <= S_IDLE;
      pc_r        <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      fault_r     <= 1'b0;
      for (int i = 0; i < NVARS; i++) vars_r[i] <= '0;
`ifdef UCORE_SEQ_CALL_STACK_EN
      sp_r <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_r[i] <= '0;
`endif
    end else begin
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      case (state_r)
        S_IDLE, S_FAULT: begin
          if (start) begin
            pc_r    <= '0;
            fault_r <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= S_RUN;
`ifdef UCORE_SEQ_CALL_STACK_EN
            sp_r    <= '0;
`endif
          end
        end
        S_RUN: begin
          pc_r <= pc_inc_s;
          case (op_s)
            OP_NOP: ;
            OP_LDI: vars_r[rd_s] <= imm_s;
            OP_ADD: vars_r[rd_s] <= rd_val_s + rs_val_s;
            OP_SUB: vars_r[rd_s] <= rd_val_s - rs_val_s;
            OP_IN:  vars_r[rd_s] <= in_data;
            OP_OUT: begin
              out_data_r  <= rd_val_s;
              out_valid_r <= 1'b1;
            end
            OP_JMP: pc_r <= tgt_s;
            OP_BNZ: begin
              if (rd_val_s != '0) pc_r <= tgt_s;
            end
`ifdef UCORE_SEQ_CALL_STACK_EN
            OP_CALL: begin
              if (sp_r == SP_FULL) begin
                pc_r    <= pc_r;
                state_r <= S_FAULT;
                fault_r <= 1'b1;
                busy_r  <= 1'b0;
              end else begin
                stack_r[sp_r[SAW-1:0]] <= pc_inc_s;
                sp_r <= sp_r + SP_ONE;
                pc_r <= tgt_s;
              end
            end
            OP_RET: begin
              if (sp_r == '0) begin
                pc_r    <= pc_r;
                state_r <= S_FAULT;
                fault_r <= 1'b1;
                busy_r  <= 1'b0;
              end else begin
                pc_r <= stack_r[sp_dec_s[SAW-1:0]];
                sp_r <= sp_dec_s;
              end
            end
`endif
            OP_HALT: begin
              pc_r    <= pc_r;
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
            default: begin
              // Illegal opcode: freeze everything and flag the fault.
              pc_r    <= pc_r;
              state_r <= S_FAULT;
              fault_r <= 1'b1;
              busy_r  <= 1'b0;
            end
          endcase
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
